// File: rtl/alu_pkg.sv
// alu_pkg: op codes {m_ext, funct7[5], funct3} and divide FSM states shared by the execute unit
package alu_pkg;
  localparam int OP_W = 5;
  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'b00000,
    OP_SLL    = 5'b00001,
    OP_SLT    = 5'b00010,
    OP_SLTU   = 5'b00011,
    OP_XOR    = 5'b00100,
    OP_SRL    = 5'b00101,
    OP_OR     = 5'b00110,
    OP_AND    = 5'b00111,
    OP_SUB    = 5'b01000,
    OP_SRA    = 5'b01101,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op_t;
  typedef enum logic [1:0] {IDLE, DIV_BUSY, DIV_DONE} div_state_t;
endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: radix-2 restoring unsigned divider, one quotient bit per cycle for XLEN cycles
module alu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);
  localparam int CW = $clog2(XLEN);
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic busy_q;
  logic [XLEN:0] shl, diff;
  assign shl = {rem_q, quo_q[XLEN-1]};
  assign diff = shl - {1'b0, dvs_q};
  // done marks the final iteration: results are complete after this edge
  assign done = busy_q && cnt_q == CW'(XLEN-1);
  assign quotient = quo_q;
  assign remainder = rem_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], !diff[XLEN]};
      cnt_q <= cnt_q + 1'b1;
      busy_q <= !done;
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered RV32/64 IM execute unit with valid/ready handshakes,
// tag passthrough, illegal-op flag and an iterative divider for the slow divide path
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  localparam int SH = $clog2(XLEN);
  div_state_t state_q;
  logic out_valid_q, out_err_q, neg_q, rneg_q, rem_sel_q;
  logic [XLEN-1:0] out_data_q, res, a_mag, b_mag, div_quo, div_rem, quo_fix, rem_fix;
  logic [TAG_W-1:0] out_tag_q, dtag_q;
  logic [2*XLEN-1:0] prod;
  logic [SH-1:0] shamt;
  logic acc, err, a_sgn, b_sgn, is_rem, div_sgn, b_zero, ovf, a_neg, b_neg, div_start, div_done;
  assign in_ready = !rst && state_q == IDLE && (!out_valid_q || out_ready);
  assign acc = in_valid && in_ready;
  assign shamt = in_b[SH-1:0];
  // sign-extend per operand so one 2*XLEN product serves MUL, MULH, MULHSU and MULHU
  assign a_sgn = in_op[1:0] == 2'b01 || in_op[1:0] == 2'b10;
  assign b_sgn = in_op[1:0] == 2'b01;
  assign prod = {{XLEN{a_sgn & in_a[XLEN-1]}}, in_a} * {{XLEN{b_sgn & in_b[XLEN-1]}}, in_b};
  assign is_rem = in_op[1];
  assign div_sgn = !in_op[0];
  assign b_zero = in_b == '0;
  assign ovf = div_sgn && in_a == {1'b1, {(XLEN-1){1'b0}}} && in_b == '1;
  assign a_neg = div_sgn && in_a[XLEN-1];
  assign b_neg = div_sgn && in_b[XLEN-1];
  assign a_mag = a_neg ? -in_a : in_a;
  assign b_mag = b_neg ? -in_b : in_b;
  assign div_start = acc && in_op[4] && in_op[2] && !b_zero && !ovf;
  assign quo_fix = neg_q ? -div_quo : div_quo;
  assign rem_fix = rneg_q ? -div_rem : div_rem;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_tag = out_tag_q;
  assign out_err = out_err_q;
  alu_div_iter #(.XLEN(XLEN)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .dividend(a_mag),
    .divisor(b_mag),
    .quotient(div_quo),
    .remainder(div_rem),
    .done(div_done)
  );
  always_comb begin
    res = '0;
    err = 1'b0;
    if (in_op[4]) begin
      case (in_op[2:0])
        3'b000: res = prod[XLEN-1:0];
        3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
        default: res = b_zero ? (is_rem ? in_a : '1) : (is_rem ? '0 : in_a);
      endcase
    end else begin
      case (in_op)
        OP_ADD: res = in_a + in_b;
        OP_SUB: res = in_a - in_b;
        OP_SLL: res = in_a << shamt;
        OP_SLT: res = XLEN'($signed(in_a) < $signed(in_b));
        OP_SLTU: res = XLEN'(in_a < in_b);
        OP_XOR: res = in_a ^ in_b;
        OP_SRL: res = in_a >> shamt;
        OP_SRA: res = $signed(in_a) >>> shamt;
        OP_OR: res = in_a | in_b;
        OP_AND: res = in_a & in_b;
        default: err = 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_tag_q <= '0;
      out_err_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      rem_sel_q <= 1'b0;
      dtag_q <= '0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (state_q == DIV_DONE) begin
        out_valid_q <= 1'b1;
        out_data_q <= rem_sel_q ? rem_fix : quo_fix;
        out_tag_q <= dtag_q;
        out_err_q <= 1'b0;
        state_q <= IDLE;
      end else if (state_q == DIV_BUSY) begin
        if (div_done) state_q <= DIV_DONE;
      end else if (div_start) begin
        state_q <= DIV_BUSY;
        neg_q <= a_neg ^ b_neg;
        rneg_q <= a_neg;
        rem_sel_q <= is_rem;
        dtag_q <= in_tag;
      end else if (acc) begin
        out_valid_q <= 1'b1;
        out_data_q <= res;
        out_tag_q <= in_tag;
        out_err_q <= err;
      end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scoreboard bench for alu_pipe at XLEN=32
module tb_alu_pipe;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [4:0] in_op = '0, in_tag = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_err;
  logic [31:0] out_data;
  logic [4:0] out_tag;
  typedef struct {
    logic [31:0] d;
    logic [4:0] t;
    logic e;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;

  alu_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] ed, input logic ee,
                      input bit push, output int waits);
    exp_t e;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    waits = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (in_ready !== 1'b1) chk("accept timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    e.d = ed; e.t = tag; e.e = ee;
    if (push) sb.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_lat(output int n, output logic ir);
    n = 0;
    ir = 1'b0;
    while (out_valid !== 1'b1 && n < 100) begin
      ir = ir | in_ready;
      @(posedge clk);
      #1 n++;
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected output: got %h tag %h expected none", out_data, out_tag);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_tag", {27'b0, out_tag}, {27'b0, e.t});
        chk("out_err", {31'b0, out_err}, {31'b0, e.e});
      end
    end
  end

  initial begin
    int w, n;
    logic ir, seen;
    #1 rst = 1'b1;
    #2;
    chk("rst out_valid", {31'b0, out_valid}, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_tag", {27'b0, out_tag}, 0);
    chk("rst out_err", {31'b0, out_err}, 0);
    chk("rst in_ready", {31'b0, in_ready}, 0);
    #20 rst = 1'b0;
    @(posedge clk); #1;
    send(5'b00000, 5, 7, 1, 12, 0, 1, w);
    chk("add lat1", {31'b0, out_valid}, 1);
    send(5'b01000, 5, 7, 2, 32'hFFFFFFFE, 0, 1, w);
    chk("sub b2b", w, 0);
    chk("sub lat1", {31'b0, out_valid}, 1);
    send(5'b01101, 32'h80000000, 32'h24, 3, 32'hF8000000, 0, 1, w);
    send(5'b00011, 1, 32'hFFFFFFFF, 4, 1, 0, 1, w);
    send(5'b01010, 9, 9, 5, 0, 1, 1, w);
    send(5'b00001, 1, 32'h21, 6, 2, 0, 1, w);
    send(5'b00010, 32'hFFFFFFFF, 1, 7, 1, 0, 1, w);
    send(5'b00101, 32'h80000000, 4, 8, 32'h08000000, 0, 1, w);
    send(5'b00100, 32'hF0F0, 32'h0FF0, 9, 32'hFF00, 0, 1, w);
    send(5'b00111, 32'hF0F0, 32'h0FF0, 10, 32'h00F0, 0, 1, w);
    send(5'b10000, 32'hFFFFFFFF, 3, 11, 32'hFFFFFFFD, 0, 1, w);
    send(5'b10001, 32'h80000000, 32'h80000000, 12, 32'h40000000, 0, 1, w);
    send(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 13, 32'hFFFFFFFE, 0, 1, w);
    send(5'b10010, 32'hFFFFFFFF, 2, 14, 32'hFFFFFFFF, 0, 1, w);
    chk("mulhsu lat1", {31'b0, out_valid}, 1);
    send(5'b00000, 3, 4, 15, 7, 0, 1, w);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 5'b00110; in_a = 32'hF0; in_b = 32'h0F; in_tag = 16;
    repeat (3) begin
      @(negedge clk);
      chk("stall data", out_data, 7);
      chk("stall tag", {27'b0, out_tag}, 15);
      chk("stall valid", {31'b0, out_valid}, 1);
      chk("stall in_ready", {31'b0, in_ready}, 0);
      @(posedge clk); #1;
    end
    sb.push_back('{d: 32'hFF, t: 5'd16, e: 1'b0});
    out_ready = 1'b1;
    @(negedge clk);
    chk("release in_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("release valid", {31'b0, out_valid}, 1);
    chk("release tag", {27'b0, out_tag}, 16);
    send(5'b10101, 100, 7, 17, 14, 0, 1, w);
    wait_lat(n, ir);
    chk("divu latency", n, 33);
    chk("divu in_ready busy", {31'b0, ir}, 0);
    send(5'b10110, -32'sd100, 7, 18, 32'hFFFFFFFE, 0, 1, w);
    wait_lat(n, ir);
    chk("rem latency", n, 33);
    send(5'b10100, -32'sd100, 7, 19, 32'hFFFFFFF2, 0, 1, w);
    wait_lat(n, ir);
    chk("div latency", n, 33);
    send(5'b10111, 32'hFFFFFFF0, 5, 20, 0, 0, 1, w);
    wait_lat(n, ir);
    send(5'b10100, 5, 0, 21, 32'hFFFFFFFF, 0, 1, w);
    chk("div0 lat1", {31'b0, out_valid}, 1);
    send(5'b10100, 32'h80000000, 32'hFFFFFFFF, 22, 32'h80000000, 0, 1, w);
    chk("ovf lat1", {31'b0, out_valid}, 1);
    send(5'b10111, 5, 0, 23, 5, 0, 1, w);
    send(5'b10110, 32'h80000000, 32'hFFFFFFFF, 24, 0, 0, 1, w);
    send(5'b10101, 1000, 3, 25, 0, 0, 0, w);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort out_valid", {31'b0, out_valid}, 0);
    chk("abort in_ready", {31'b0, in_ready}, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("abort no output", {31'b0, seen}, 0);
    @(posedge clk); #1;
    send(5'b00000, 2, 3, 26, 5, 0, 1, w);
    chk("post-abort add", {31'b0, out_valid}, 1);
    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
